// File: rtl/mem_loader_pkg.sv
// Shared definitions for the memory loader: FSM and stream-segment encodings,
// header length, memory byte strides and the header capacity check.
// Optional feature macro: LOADER_VERIFY_EN (read-back checksum verification).
package mem_loader_pkg;

    localparam int LOADER_HDR_BYTES = 4;
    localparam int IMEM_STRIDE      = 4;
    localparam int DMEM_STRIDE      = 8;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HDR    = 3'd1,
        S_IMEM   = 3'd2,
        S_DMEM   = 3'd3,
        S_RUN    = 3'd4,
        S_ERROR  = 3'd5
`ifdef LOADER_VERIFY_EN
        , S_VERIFY = 3'd6
`endif
    } state_t;

    // Which part of the byte stream the next accepted byte belongs to.
    typedef enum logic [1:0] {
        SEG_HDR  = 2'd0,
        SEG_IMEM = 2'd1,
        SEG_DMEM = 2'd2,
        SEG_END  = 2'd3
    } seg_t;

`ifdef LOADER_VERIFY_EN
    typedef enum logic [1:0] {
        V_IMEM  = 2'd0,
        V_DMEM  = 2'd1,
        V_DRAIN = 2'd2
    } vphase_t;
`endif

    function automatic logic hdr_too_big(input logic [15:0] n, input int limit);
        return int'({16'd0, n}) > limit;
    endfunction

endpackage

// File: rtl/mem_loader_word_assembler.sv
// Little-endian byte-to-word assembler. The first byte of a word lands in
// bits [7:0]. When the last byte of a word is taken, the full word is copied
// into a holding register and word_valid pulses for the following cycle, so
// assembly of the next word can continue while the word is being written.
module word_assembler #(
    parameter int WORD_BYTES = 4
) (
    input  logic                    clk,
    input  logic                    arst_n,
    input  logic                    clear,
    input  logic                    take,
    input  logic [7:0]              data,
    output logic                    last,
    output logic [8*WORD_BYTES-1:0] word_next,
    output logic [8*WORD_BYTES-1:0] word,
    output logic                    word_valid
);

    localparam int CW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

    logic [CW-1:0]           cnt;
    logic [8*WORD_BYTES-1:0] sh;

    assign word_next = {data, sh[8*WORD_BYTES-1:8]};
    assign last      = take && (cnt == CW'(WORD_BYTES - 1));

    // Shift bytes in from the top; latch the completed word into the holding register.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt        <= '0;
            sh         <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else if (clear) begin
            cnt        <= '0;
            sh         <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= last;
            if (take) begin
                sh  <= word_next;
                cnt <= last ? '0 : cnt + CW'(1);
            end
            if (last) begin
                word <= word_next;
            end
        end
    end

endmodule

// File: rtl/mem_loader.sv
// Host-side loader: takes a byte stream (N_I, N_D header then payload), writes
// the instruction memory (32-bit words) and the data memory (64-bit words)
// through the cpu external ports, then enables the cpu.
// Optional feature macro: LOADER_VERIFY_EN adds a read-back checksum pass
// before the cpu is enabled.
//
// state  | meaning
// IDLE   | after reset, waiting for start
// HDR    | collecting the 4 header bytes, then capacity check
// IMEM   | writing instruction words as they complete
// DMEM   | writing data words as they complete
// VERIFY | (LOADER_VERIFY_EN) reading back every word and comparing sums
// RUN    | cpu enabled, load done
// ERROR  | header over capacity or verify mismatch
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int IMEM_WORDS = 512,
    parameter int DMEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        start,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [7:0]  s_data,
    output logic [63:0] addr_ext,
    output logic        wen_ext,
    output logic        ren_ext,
    output logic [31:0] wdata_ext,
    input  logic [31:0] rdata_ext,
    output logic [63:0] addr_ext_2,
    output logic        wen_ext_2,
    output logic        ren_ext_2,
    output logic [63:0] wdata_ext_2,
    input  logic [63:0] rdata_ext_2,
    output logic        cpu_enable,
    output logic        busy,
    output logic        done,
    output logic        error
);

`ifdef LOADER_VERIFY_EN
    localparam state_t LOAD_END = S_VERIFY;
`else
    localparam state_t LOAD_END = S_RUN;
`endif

    state_t      state, state_next;
    seg_t        seg;
    logic [15:0] n_i, n_d, in_words, k, k_next;
    logic        start_acc, accept, take32, take64;
    logic        last32, last64, v32, v64;
    logic [31:0] wn32, word32;
    logic [63:0] word64, dmem_word_next_unused;

    assign start_acc = start && (state == S_IDLE || state == S_RUN || state == S_ERROR);
    assign accept    = s_valid && s_ready;
    // The header is exactly one 32-bit word, so it shares the imem assembler.
    assign take32    = accept && (seg == SEG_HDR || seg == SEG_IMEM);
    assign take64    = accept && (seg == SEG_DMEM);

    word_assembler #(.WORD_BYTES(LOADER_HDR_BYTES)) u_asm32 (
        .clk        (clk),
        .arst_n     (arst_n),
        .clear      (start_acc),
        .take       (take32),
        .data       (s_data),
        .last       (last32),
        .word_next  (wn32),
        .word       (word32),
        .word_valid (v32)
    );

    word_assembler #(.WORD_BYTES(DMEM_STRIDE)) u_asm64 (
        .clk        (clk),
        .arst_n     (arst_n),
        .clear      (start_acc),
        .take       (take64),
        .data       (s_data),
        .last       (last64),
        .word_next  (dmem_word_next_unused),
        .word       (word64),
        .word_valid (v64)
    );

    // Byte-side segment tracking: routes each accepted byte to the right
    // assembler even while the FSM is still finishing the previous segment.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            seg      <= SEG_END;
            n_i      <= '0;
            n_d      <= '0;
            in_words <= '0;
        end else if (start_acc) begin
            seg      <= SEG_HDR;
            in_words <= '0;
        end else begin
            case (seg)
                SEG_HDR: if (last32) begin
                    n_i      <= wn32[15:0];
                    n_d      <= wn32[31:16];
                    in_words <= '0;
                    if (hdr_too_big(wn32[15:0], IMEM_WORDS) || hdr_too_big(wn32[31:16], DMEM_WORDS))
                        seg <= SEG_END;
                    else if (wn32[15:0] != 16'd0)
                        seg <= SEG_IMEM;
                    else if (wn32[31:16] != 16'd0)
                        seg <= SEG_DMEM;
                    else
                        seg <= SEG_END;
                end
                SEG_IMEM: if (last32) begin
                    if (in_words == n_i - 16'd1) begin
                        in_words <= '0;
                        seg      <= (n_d != 16'd0) ? SEG_DMEM : SEG_END;
                    end else begin
                        in_words <= in_words + 16'd1;
                    end
                end
                SEG_DMEM: if (last64) begin
                    if (in_words == n_d - 16'd1) begin
                        in_words <= '0;
                        seg      <= SEG_END;
                    end else begin
                        in_words <= in_words + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // FSM state and word index register.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state <= S_IDLE;
            k     <= '0;
        end else begin
            state <= state_next;
            k     <= k_next;
        end
    end

`ifdef LOADER_VERIFY_EN
    vphase_t     vph, vph_next;
    logic        pend32, pend64;
    logic [31:0] wsum32, rsum32;
    logic [63:0] wsum64, rsum64;

    // Running sums of written and read-back words; read data arrives one cycle after ren.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            vph    <= V_IMEM;
            pend32 <= 1'b0;
            pend64 <= 1'b0;
            wsum32 <= '0;
            rsum32 <= '0;
            wsum64 <= '0;
            rsum64 <= '0;
        end else begin
            pend32 <= ren_ext;
            pend64 <= ren_ext_2;
            if (start_acc) begin
                wsum32 <= '0;
                rsum32 <= '0;
                wsum64 <= '0;
                rsum64 <= '0;
            end else begin
                if (wen_ext)   wsum32 <= wsum32 + wdata_ext;
                if (wen_ext_2) wsum64 <= wsum64 + wdata_ext_2;
                if (pend32)    rsum32 <= rsum32 + rdata_ext;
                if (pend64)    rsum64 <= rsum64 + rdata_ext_2;
            end
            if (state != S_VERIFY)
                vph <= (n_i != 16'd0) ? V_IMEM : V_DMEM;
            else
                vph <= vph_next;
        end
    end
`else
    logic unused_rdata;
    assign unused_rdata = ^{rdata_ext, rdata_ext_2};
`endif

    // Next-state and output decode.
    always_comb begin
        state_next  = state;
        k_next      = k;
        s_ready     = 1'b0;
        addr_ext    = '0;
        wen_ext     = 1'b0;
        ren_ext     = 1'b0;
        wdata_ext   = '0;
        addr_ext_2  = '0;
        wen_ext_2   = 1'b0;
        ren_ext_2   = 1'b0;
        wdata_ext_2 = '0;
        cpu_enable  = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        error       = 1'b0;
`ifdef LOADER_VERIFY_EN
        vph_next    = vph;
`endif
        case (state)
            S_IDLE: begin
                if (start_acc) begin
                    state_next = S_HDR;
                    k_next     = '0;
                end
            end
            S_HDR: begin
                busy    = 1'b1;
                s_ready = (seg != SEG_END);
                if (v32) begin
                    if (hdr_too_big(n_i, IMEM_WORDS) || hdr_too_big(n_d, DMEM_WORDS))
                        state_next = S_ERROR;
                    else if (n_i != 16'd0)
                        state_next = S_IMEM;
                    else if (n_d != 16'd0)
                        state_next = S_DMEM;
                    else
                        state_next = S_RUN;
                end
            end
            S_IMEM: begin
                busy    = 1'b1;
                s_ready = (seg != SEG_END);
                if (v32) begin
                    wen_ext   = 1'b1;
                    addr_ext  = 64'(k) * 64'(IMEM_STRIDE);
                    wdata_ext = word32;
                    if (k == n_i - 16'd1) begin
                        k_next     = '0;
                        state_next = (n_d != 16'd0) ? S_DMEM : LOAD_END;
                    end else begin
                        k_next = k + 16'd1;
                    end
                end
            end
            S_DMEM: begin
                busy    = 1'b1;
                s_ready = (seg != SEG_END);
                if (v64) begin
                    wen_ext_2   = 1'b1;
                    addr_ext_2  = 64'(k) * 64'(DMEM_STRIDE);
                    wdata_ext_2 = word64;
                    if (k == n_d - 16'd1) begin
                        k_next     = '0;
                        state_next = LOAD_END;
                    end else begin
                        k_next = k + 16'd1;
                    end
                end
            end
`ifdef LOADER_VERIFY_EN
            S_VERIFY: begin
                busy = 1'b1;
                case (vph)
                    V_IMEM: begin
                        ren_ext  = 1'b1;
                        addr_ext = 64'(k) * 64'(IMEM_STRIDE);
                        if (k == n_i - 16'd1) begin
                            k_next   = '0;
                            vph_next = (n_d != 16'd0) ? V_DMEM : V_DRAIN;
                        end else begin
                            k_next = k + 16'd1;
                        end
                    end
                    V_DMEM: begin
                        ren_ext_2  = 1'b1;
                        addr_ext_2 = 64'(k) * 64'(DMEM_STRIDE);
                        if (k == n_d - 16'd1) begin
                            k_next   = '0;
                            vph_next = V_DRAIN;
                        end else begin
                            k_next = k + 16'd1;
                        end
                    end
                    default: begin
                        if (!pend32 && !pend64)
                            state_next = (wsum32 == rsum32 && wsum64 == rsum64) ? S_RUN : S_ERROR;
                    end
                endcase
            end
`endif
            S_RUN: begin
                cpu_enable = 1'b1;
                done       = 1'b1;
                if (start_acc) begin
                    state_next = S_HDR;
                    k_next     = '0;
                end
            end
            S_ERROR: begin
                error = 1'b1;
                if (start_acc) begin
                    state_next = S_HDR;
                    k_next     = '0;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader: hand-written corner sequences plus a
// table of randomized loads compared against a byte-level reference model.
// Build with LOADER_VERIFY_EN defined to exercise the read-back verify path.
module tb_mem_loader;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        start = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [7:0]  s_data = 8'h00;
    logic [63:0] addr_ext, addr_ext_2;
    logic        wen_ext, ren_ext, wen_ext_2, ren_ext_2;
    logic [31:0] wdata_ext;
    logic [31:0] rdata_ext = 32'h0;
    logic [63:0] wdata_ext_2;
    logic [63:0] rdata_ext_2 = 64'h0;
    logic        cpu_enable, busy, done, error;

    mem_loader dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .start       (start),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .addr_ext    (addr_ext),
        .wen_ext     (wen_ext),
        .ren_ext     (ren_ext),
        .wdata_ext   (wdata_ext),
        .rdata_ext   (rdata_ext),
        .addr_ext_2  (addr_ext_2),
        .wen_ext_2   (wen_ext_2),
        .ren_ext_2   (ren_ext_2),
        .wdata_ext_2 (wdata_ext_2),
        .rdata_ext_2 (rdata_ext_2),
        .cpu_enable  (cpu_enable),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model behind the external ports; read data is registered.
    logic [31:0] imem [0:511];
    logic [63:0] dmem [0:1023];
    bit          corrupt_w1 = 1'b0;

    always @(posedge clk) begin
        if (wen_ext)
            imem[addr_ext[10:2]] <= (corrupt_w1 && addr_ext == 64'd4) ? (wdata_ext ^ 32'h1) : wdata_ext;
        if (wen_ext_2)
            dmem[addr_ext_2[12:3]] <= wdata_ext_2;
        rdata_ext   <= ren_ext   ? imem[addr_ext[10:2]]   : 32'h0;
        rdata_ext_2 <= ren_ext_2 ? dmem[addr_ext_2[12:3]] : 64'h0;
    end

    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
        int          cyc;
        logic        rdy;
    } wr_t;

    wr_t w32_q[$];
    wr_t w64_q[$];
    int  acc_cyc[$];
    int  rd_seen = 0;
    bit  en_seen = 1'b0;

    always @(negedge clk) begin
        if (wen_ext)   w32_q.push_back('{addr_ext, 64'(wdata_ext), cyc, s_ready});
        if (wen_ext_2) w64_q.push_back('{addr_ext_2, wdata_ext_2, cyc, s_ready});
        if (ren_ext || ren_ext_2) rd_seen++;
        if (cpu_enable) en_seen = 1'b1;
    end

    typedef logic [7:0] bq_t [$];

    typedef struct {
        int n_i;
        int n_d;
        int prob;
        bit hdr_err;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Drives bytes with s_valid asserted prob% of cycles; records the cycle of each acceptance.
    task automatic send(input bq_t b, input int prob);
        int i = 0;
        int guard = 0;
        acc_cyc.delete();
        while (i < b.size() && guard < 40000) begin
            @(negedge clk);
            s_data  = b[i];
            s_valid = (int'($urandom_range(99)) < prob);
            #4;
            if (s_valid && s_ready) begin
                acc_cyc.push_back(cyc + 1);
                i++;
            end
            guard++;
        end
        chk("bytes_accepted", 64'(i), 64'(b.size()));
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic wait_term(input int budget);
        int n = 0;
        while (!(done || error) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("terminal_reached", 64'(done || error), 64'd1);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_ctl"}, 64'({s_ready, wen_ext, ren_ext, wen_ext_2, ren_ext_2, cpu_enable, busy, done, error}), 64'd0);
        chk({tag, "_addr"}, addr_ext | addr_ext_2, 64'd0);
        chk({tag, "_wdata"}, 64'(wdata_ext) | wdata_ext_2, 64'd0);
    endtask

    // Example load: two imem words, one dmem word.
    task automatic run_t1(input string tag);
        bq_t b;
        b = '{8'h02, 8'h00, 8'h01, 8'h00,
              8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00,
              8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        w32_q.delete();
        w64_q.delete();
        pulse_start();
        chk({tag, "_hdr_busy"}, 64'({busy, s_ready, done}), 64'b110);
        send(b, 100);
        chk({tag, "_dstrobe"}, 64'({wen_ext_2, done}), 64'b10);
        chk({tag, "_daddr"}, addr_ext_2, 64'd0);
        chk({tag, "_ddata"}, wdata_ext_2, 64'h8877665544332211);
`ifndef LOADER_VERIFY_EN
        @(negedge clk);
        chk({tag, "_run_next"}, 64'({cpu_enable, done, busy}), 64'b110);
`else
        wait_term(100);
        chk({tag, "_run"}, 64'({cpu_enable, done, error}), 64'b110);
`endif
        chk({tag, "_n32"}, 64'(w32_q.size()), 64'd2);
        chk({tag, "_n64"}, 64'(w64_q.size()), 64'd1);
        if (w32_q.size() == 2 && acc_cyc.size() == 20) begin
            chk({tag, "_a0"}, w32_q[0].addr, 64'd0);
            chk({tag, "_d0"}, w32_q[0].data, 64'h00000013);
            chk({tag, "_a1"}, w32_q[1].addr, 64'd4);
            chk({tag, "_d1"}, w32_q[1].data, 64'h00100093);
            chk({tag, "_rdy_strobe"}, 64'(w32_q[0].rdy), 64'd1);
            chk({tag, "_t0"}, 64'(w32_q[0].cyc), 64'(acc_cyc[7]));
            chk({tag, "_t1"}, 64'(w32_q[1].cyc), 64'(acc_cyc[11]));
        end
    endtask

    // Randomized load checked against the byte-level reference model.
    task automatic run_load(input int idx, input int n_i, input int n_d, input int prob, input bit hdr_err);
        bq_t         b;
        logic [31:0] ew [$];
        logic [63:0] ed [$];
        logic [31:0] w;
        logic [63:0] dw;
        logic [7:0]  bt;
        bit          exp_fail;
        int          li;
        string       tag;
        tag = $sformatf("vec%0d", idx);
        exp_fail = hdr_err || corrupt_w1;
        w32_q.delete();
        w64_q.delete();
        b.push_back(8'(n_i));
        b.push_back(8'(n_i >> 8));
        b.push_back(8'(n_d));
        b.push_back(8'(n_d >> 8));
        if (!hdr_err) begin
            for (int k = 0; k < n_i; k++) begin
                w = 32'd0;
                for (int j = 0; j < 4; j++) begin
                    bt = 8'($urandom_range(255));
                    b.push_back(bt);
                    w = w | (32'(bt) << (8 * j));
                end
                ew.push_back(w);
            end
            for (int k = 0; k < n_d; k++) begin
                dw = 64'd0;
                for (int j = 0; j < 8; j++) begin
                    bt = 8'($urandom_range(255));
                    b.push_back(bt);
                    dw = dw | (64'(bt) << (8 * j));
                end
                ed.push_back(dw);
            end
        end
        pulse_start();
        send(b, prob);
        wait_term(3000);
        chk({tag, "_status"}, 64'({error, cpu_enable, done}), exp_fail ? 64'b100 : 64'b011);
        chk({tag, "_n32"}, 64'(w32_q.size()), 64'(ew.size()));
        chk({tag, "_n64"}, 64'(w64_q.size()), 64'(ed.size()));
        for (int k = 0; k < ew.size() && k < w32_q.size(); k++) begin
            li = 4 + 4 * k + 3;
            chk($sformatf("%s_i%0d_addr", tag, k), w32_q[k].addr, 64'(4 * k));
            chk($sformatf("%s_i%0d_data", tag, k), w32_q[k].data, 64'(ew[k]));
            if (li < acc_cyc.size())
                chk($sformatf("%s_i%0d_time", tag, k), 64'(w32_q[k].cyc), 64'(acc_cyc[li]));
        end
        for (int k = 0; k < ed.size() && k < w64_q.size(); k++) begin
            li = 4 + 4 * n_i + 8 * k + 7;
            chk($sformatf("%s_d%0d_addr", tag, k), w64_q[k].addr, 64'(8 * k));
            chk($sformatf("%s_d%0d_data", tag, k), w64_q[k].data, ed[k]);
            if (li < acc_cyc.size())
                chk($sformatf("%s_d%0d_time", tag, k), 64'(w64_q[k].cyc), 64'(acc_cyc[li]));
        end
    endtask

    initial begin
        bq_t b;
        vecs[0] = '{2, 1, 50, 1'b0};
        vecs[1] = '{0, 3, 70, 1'b0};
        vecs[2] = '{5, 0, 60, 1'b0};
        vecs[3] = '{0, 0, 30, 1'b0};
        vecs[4] = '{513, 0, 100, 1'b1};
        vecs[5] = '{0, 1025, 100, 1'b1};
        vecs[6] = '{512, 1, 100, 1'b0};
        vecs[7] = '{1, 1024, 100, 1'b0};
        vecs[8] = '{7, 4, 25, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        arst_n = 1'b1;
        @(negedge clk);
        chk_outputs_zero("idle");

        // Example load
        run_t1("t1");

        // Empty load: RUN one cycle after the 4th header byte
        w32_q.delete();
        w64_q.delete();
        pulse_start();
        b = '{8'h00, 8'h00, 8'h00, 8'h00};
        send(b, 100);
        chk("t2_check_cycle", 64'({done, busy}), 64'b01);
        @(negedge clk);
        chk("t2_run", 64'({cpu_enable, done, busy}), 64'b110);
        chk("t2_no_writes", 64'(w32_q.size() + w64_q.size()), 64'd0);

        // Over-capacity header
        pulse_start();
        b = '{8'h01, 8'h02, 8'h00, 8'h00};
        send(b, 100);
        @(negedge clk);
        chk("t3_error", 64'({error, s_ready, cpu_enable, busy}), 64'b1000);
        pulse_start();
        chk("t3_restart", 64'({error, busy, s_ready}), 64'b011);

        // Reset mid-load after 6 imem bytes, then reload
        w32_q.delete();
        w64_q.delete();
        b = '{8'h02, 8'h00, 8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00};
        send(b, 100);
        @(negedge clk);
        arst_n = 1'b0;
        #1;
        chk_outputs_zero("t5_reset");
        chk("t5_partial_writes", 64'(w32_q.size()), 64'd1);
        @(negedge clk);
        arst_n = 1'b1;
        run_t1("t5_reload");

        // Table of randomized loads
        for (int i = 0; i < 9; i++)
            run_load(i, vecs[i].n_i, vecs[i].n_d, vecs[i].prob, vecs[i].hdr_err);

`ifdef LOADER_VERIFY_EN
        // Backdoor corruption of imem word 1 must be caught by read-back
        en_seen = 1'b0;
        corrupt_w1 = 1'b1;
        run_load(9, 2, 1, 100, 1'b0);
        corrupt_w1 = 1'b0;
        chk("t6_cpu_never_enabled", 64'(en_seen), 64'd0);
        chk("t6_reads_seen", 64'(rd_seen > 0), 64'd1);
`else
        chk("no_reads", 64'(rd_seen), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
